// File: rtl/hack_pc.sv
// Hack program counter (clr > load > inc > hold) with "@END / 0;JMP" halt-loop detection.
// Optional taken-load counter port jump_cnt is built when HACK_PC_JUMP_CNT_EN is defined.
module hack_pc #(
    parameter int WIDTH      = 16,
    parameter int HALT_COUNT = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] in,
    input  logic             load,
    input  logic             inc,
    input  logic             clr,
    output logic [WIDTH-1:0] out,
    output logic             halted
`ifdef HACK_PC_JUMP_CNT_EN
    ,
    output logic [15:0]      jump_cnt
`endif
);

    localparam logic [WIDTH-1:0] ONE_W     = {{(WIDTH-1){1'b0}}, 1'b1};
    localparam logic [3:0]       HALT_CNT4 = 4'(HALT_COUNT);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_TRACK,
        ST_HALTED
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] out_q, out_d;
    logic [WIDTH-1:0] tgt_q, tgt_d;
    logic [3:0]       cnt_q, cnt_d;

    logic             load_eff;
    logic             inc_eff;
    logic [WIDTH-1:0] out_dec;
    logic [WIDTH-1:0] out_inc;
    logic [WIDTH-1:0] tgt_inc;
    logic [3:0]       cnt_inc;
    logic             entry_hit;
    logic             repeat_hit;

    // Width-exact helpers keep the mod-2^WIDTH comparisons from widening to 32 bits.
    always_comb begin
        load_eff   = load & ~clr;
        inc_eff    = inc & ~load & ~clr;
        out_dec    = out_q - ONE_W;
        out_inc    = out_q + ONE_W;
        tgt_inc    = tgt_q + ONE_W;
        cnt_inc    = cnt_q + 4'd1;
        entry_hit  = load_eff && (in == out_dec);
        repeat_hit = load_eff && (in == tgt_q) && (out_q == tgt_inc);
    end

    always_comb begin
        out_d = out_q;
        if (clr) begin
            out_d = '0;
        end else if (load) begin
            out_d = in;
        end else if (inc) begin
            out_d = out_inc;
        end
    end

    always_comb begin
        state_d = state_q;
        tgt_d   = tgt_q;
        cnt_d   = cnt_q;
        if (clr) begin
            state_d = ST_IDLE;
            cnt_d   = '0;
        end else begin
            unique case (state_q)
                ST_IDLE: begin
                    if (entry_hit) begin
                        tgt_d   = in;
                        cnt_d   = 4'd1;
                        state_d = (HALT_CNT4 == 4'd1) ? ST_HALTED : ST_TRACK;
                    end
                end
                ST_TRACK: begin
                    if (repeat_hit) begin
                        cnt_d = cnt_inc;
                        if (cnt_inc == HALT_CNT4) begin
                            state_d = ST_HALTED;
                        end
                    end else if (load_eff) begin
                        // A breaking load may itself start a fresh idiom.
                        if (entry_hit) begin
                            tgt_d   = in;
                            cnt_d   = 4'd1;
                            state_d = ST_TRACK;
                        end else begin
                            cnt_d   = '0;
                            state_d = ST_IDLE;
                        end
                    end else if (inc_eff && (out_q != tgt_q)) begin
                        cnt_d   = '0;
                        state_d = ST_IDLE;
                    end
                end
                ST_HALTED: begin
                    state_d = ST_HALTED;
                end
                default: begin
                    state_d = ST_IDLE;
                    cnt_d   = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_q   <= '0;
            tgt_q   <= '0;
            cnt_q   <= '0;
            state_q <= ST_IDLE;
        end else begin
            out_q   <= out_d;
            tgt_q   <= tgt_d;
            cnt_q   <= cnt_d;
            state_q <= state_d;
        end
    end

    assign out    = out_q;
    assign halted = (state_q == ST_HALTED);

`ifdef HACK_PC_JUMP_CNT_EN
    logic [15:0] jump_cnt_q, jump_cnt_d;

    always_comb begin
        jump_cnt_d = jump_cnt_q;
        if (clr) begin
            jump_cnt_d = '0;
        end else if (load && (jump_cnt_q != '1)) begin
            jump_cnt_d = jump_cnt_q + 16'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            jump_cnt_q <= '0;
        end else begin
            jump_cnt_q <= jump_cnt_d;
        end
    end

    assign jump_cnt = jump_cnt_q;
`endif

endmodule
